multicycle_control_unit: RTL
============================

# multicycle_control_unit

Finite-state control unit for the multi-cycle RV32I datapath; the sequential successor to the single-cycle opcode decoder. It sequences fetch, decode, execute, memory and write-back over several cycles, handshakes with a shared instruction/data memory that has variable latency, and flags illegal opcodes and memory timeouts. It also keeps a retired-instruction counter. It drives the datapath muxes, write enables and ALU-op select.

## Interface
Parameters:
- TIMEOUT, default 16: maximum memory wait cycles before trapping. 0 disables the watchdog.
- CNT_W, default 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- run  in  1  leaves IDLE when high.
- opcode  in  7  instruction register bits [6:0]; valid from DECODE onward.
- zero  in  1  ALU zero flag, used in BRANCH.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_we  out  1  write strobe; only with mem_req.
- i_or_d  out  1  0 = PC address, 1 = ALU-result address.
- ir_write, pc_write, reg_write, mem_to_reg  out  1 each  datapath enables and select.
- alu_src_a  out  2  00 = PC, 01 = rs1, 10 = old PC.
- alu_src_b  out  2  00 = rs2, 01 = constant 4, 10 = immediate.
- alu_op  out  2  00 = add, 01 = branch compare (sub), 10 = R-type funct, 11 = I-type funct.
- trap  out  1  sticky; high in TRAP.
- trap_cause  out  1  0 = illegal opcode, 1 = memory timeout.
- retired  out  CNT_W  count of completed instructions.

## Operation
- Moore FSM. All outputs are decoded from the state, except that ir_write and pc_write in FETCH are qualified by mem_ready.
- FETCH: mem_req=1, i_or_d=0, alu_src_a=00, alu_src_b=01, alu_op=00. On mem_ready: ir_write=1, pc_write=1, go to DECODE.
- DECODE (all control outputs 0; next state chosen by opcode):
  - 0110011 → EXEC_R.
  - 0010011 → EXEC_I.
  - 0000011 or 0100011 → MEM_ADDR.
  - 1100011 → BRANCH.
  - 0000000 → NOP; retires and returns to FETCH.
  - Anything else → TRAP with cause 0.
- EXEC_R: src_a=01, src_b=00, alu_op=10 → WB_ALU.
- EXEC_I: src_a=01, src_b=10, alu_op=11 → WB_ALU.
- MEM_ADDR: src_a=01, src_b=10, alu_op=00. Next state is MEM_RD for a load, MEM_WR for a store.
- MEM_RD: mem_req=1, i_or_d=1; on mem_ready → WB_MEM.
- MEM_WR: mem_req=1, mem_we=1, i_or_d=1; on mem_ready, retire → FETCH.
- WB_ALU: reg_write=1, mem_to_reg=0; retire → FETCH.
- WB_MEM: reg_write=1, mem_to_reg=1; retire → FETCH.
- BRANCH: src_a=01, src_b=00, alu_op=01, pc_write=zero; retire → FETCH.
- TRAP: all control outputs 0, trap=1. Leaves only via reset.
- Watchdog: a wait counter clears on entering any memory state and increments each cycle that mem_req=1 and mem_ready=0. If TIMEOUT≠0 and the counter reaches TIMEOUT while mem_ready is still 0, go to TRAP with cause 1. A mem_ready in the same cycle wins over the timeout.
- retired increments by 1 on each retire and wraps modulo 2^CNT_W.

## Timing
- Reset (rst_n=0 at an edge) puts the FSM in IDLE, clears retired, the wait counter and trap_cause, and drives every output to 0. This applies mid-instruction, including during a pending memory access; mem_req drops in the following cycle.
- IDLE → FETCH on the first edge with run=1. run is ignored in every other state.
- Latency with zero-wait memory (mem_ready=1 on the first request cycle), counted from FETCH entry to the next FETCH entry:
  - NOP: 2 cycles.
  - BRANCH: 3 cycles.
  - R-type, I-type and store: 4 cycles.
  - Load: 5 cycles.
  - Each memory wait cycle adds 1.
- mem_req stays high and the address-select outputs stay stable until mem_ready is seen.

## Configuration
- CU_JUMP_EN defined: adds JAL (1101111) and JALR (1100111) through a JUMP state followed by WB_PC.
  - JUMP: alu_src_a=10 for JAL or 01 for JALR, src_b=10, alu_op=00, pc_write=1.
  - WB_PC: reg_write=1, writes the link value PC+4; retire.
  - Latency is 4 cycles.
- CU_JUMP_EN undefined: both opcodes go to TRAP with cause 0.

## Test plan
- Reset, then run=1 with mem_ready tied high and the sequence R-type, load, store, branch (zero=1): state sequences match Operation, retired=4 after 16 cycles, and pc_write is pulsed in BRANCH.
- Load with mem_ready delayed 3 cycles in MEM_RD: mem_req held for 4 cycles with i_or_d=1; WB_MEM is entered the cycle after mem_ready.
- TIMEOUT=4 and mem_ready never asserted in FETCH: trap=1 and trap_cause=1 after 4 wait cycles; state remains TRAP until rst_n=0.
- Opcode 1111111: TRAP with cause 0 after DECODE, retired unchanged. With CU_JUMP_EN, opcode 1101111 retires in 4 cycles with reg_write pulsed once.
- CNT_W=3: after 9 NOPs, retired=1 (wrap).
- rst_n=0 asserted during MEM_WR: the next cycle shows all outputs 0, state IDLE and retired=0.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// rtl/multicycle_control_unit_if.sv - shared instruction/data memory handshake bundle
// master = control unit (issues requests), slave = memory (completes them).
interface multicycle_control_unit_if;
  logic mem_req;
  logic mem_we;
  logic i_or_d;
  logic mem_ready;

  modport master (output mem_req, output mem_we, output i_or_d, input mem_ready);
  modport slave  (input mem_req, input mem_we, input i_or_d, output mem_ready);
endinterface

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle RV32I control FSM with memory watchdog and retire counter
// Optional feature: define CU_JUMP_EN to add JAL/JALR sequencing through JUMP and WB_PC.
module multicycle_control_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            run,
  input  logic [6:0]                      opcode,
  input  logic                            zero,
  multicycle_control_unit_if.master       mem,
  output logic                            ir_write,
  output logic                            pc_write,
  output logic                            reg_write,
  output logic                            mem_to_reg,
  output logic [1:0]                      alu_src_a,
  output logic [1:0]                      alu_src_b,
  output logic [1:0]                      alu_op,
  output logic                            trap,
  output logic                            trap_cause,
  output logic [CNT_W-1:0]                retired
);

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_NOP  = 7'b0000000;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  // Wide enough to hold TIMEOUT itself; never narrower than one bit.
  localparam int WAIT_W = $clog2(TIMEOUT + 2);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD,
    S_MEM_WR, S_WB_ALU, S_WB_MEM, S_BRANCH, S_TRAP, S_JUMP, S_WB_PC
  } state_t;

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               cause_q, cause_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               retire;
  logic               waiting;
  logic               timeout_hit;

  assign timeout_hit = (TIMEOUT != 0) && (wait_q == WAIT_W'(TIMEOUT - 1));

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    cause_d    = cause_q;
    retire     = 1'b0;
    waiting    = 1'b0;
    mem.mem_req = 1'b0;
    mem.mem_we  = 1'b0;
    mem.i_or_d  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    trap       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem.mem_req = 1'b1;
        alu_src_b   = 2'b01;
        if (mem.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else begin
          waiting = 1'b1;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_R:         state_d = S_EXEC_R;
          OP_I:         state_d = S_EXEC_I;
          OP_LD, OP_ST: state_d = S_MEM_ADDR;
          OP_BR:        state_d = S_BRANCH;
          OP_NOP: begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
`ifdef CU_JUMP_EN
          OP_JAL, OP_JALR: state_d = S_JUMP;
`endif
          default: begin
            state_d = S_TRAP;
            cause_d = 1'b0;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
        state_d   = S_WB_ALU;
      end
      S_MEM_ADDR: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_ST) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem.mem_req = 1'b1;
        mem.i_or_d  = 1'b1;
        if (mem.mem_ready) state_d = S_WB_MEM;
        else               waiting = 1'b1;
      end
      S_MEM_WR: begin
        mem.mem_req = 1'b1;
        mem.mem_we  = 1'b1;
        mem.i_or_d  = 1'b1;
        if (mem.mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          waiting = 1'b1;
        end
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b01;
        pc_write  = zero;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
`ifdef CU_JUMP_EN
      S_JUMP: begin
        alu_src_a = (opcode == OP_JALR) ? 2'b01 : 2'b10;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_WB_PC;
      end
      S_WB_PC: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
`endif
      S_TRAP: begin
        trap = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // A completing access never reaches here with waiting set, so ready wins.
    if (waiting && timeout_hit) begin
      state_d = S_TRAP;
      cause_d = 1'b1;
    end

    if (state_d != state_q) wait_d = '0;
    else if (waiting)       wait_d = wait_q + WAIT_W'(1);

    retired_d = retired_q + CNT_W'(retire);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wait_q    <= '0;
      cause_q   <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      cause_q   <= cause_d;
      retired_q <= retired_d;
    end
  end

  assign trap_cause = cause_q;
  assign retired    = retired_q;

endmodule
